load_writeback: RTL

- Initiator-side counterpart of the register file write port: takes a load request from the execute stage, performs one word read on the memory bus, then formats the data and drives the register file `write_en`/`write_addr`/`write_data`.
- Formatting covers byte/half extraction, sign or zero extension, and LWL/LWR merging.
- Handles one load at a time and sits between the pipeline, the memory bus and the register file.

---
 rtl/mips_pkg.sv | 79 +++++++
 rtl/load_format.sv | 39 +++
 rtl/load_writeback.sv | 100 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and helpers for the load/writeback path: opcodes, FSM states,
// byte-lane masks and the small decode functions used by the datapath.
package mips_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LWL = 3'd2,
    LW  = 3'd3,
    LBU = 3'd4,
    LHU = 3'd5,
    LWR = 3'd6
  } load_op_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } lw_state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_LANE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Opcode 3'b111 has no load meaning; it is folded onto LW.
  function automatic load_op_t decode_op(input logic [2:0] raw);
    load_op_t op;
    if (raw == 3'b111) op = LW;
    else               op = load_op_t'(raw);
    return op;
  endfunction

  function automatic logic is_misaligned(input load_op_t op, input logic [1:0] off);
    logic bad;
    case (op)
      LH, LHU: bad = off[0];
      LW:      bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input load_op_t op, input logic [1:0] off);
    logic [3:0] be;
    case (op)
      LB, LBU: be = BE_LANE0 << off;
      LH, LHU: be = off[1] ? BE_HALF_HI : BE_HALF_LO;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  // Bytes of rt_old that survive an LWL: the low (3-o) bytes.
  function automatic logic [31:0] lwl_keep_mask(input logic [1:0] off);
    logic [31:0] m;
    case (off)
      2'd0:    m = 32'h00FF_FFFF;
      2'd1:    m = 32'h0000_FFFF;
      2'd2:    m = 32'h0000_00FF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // Bytes of rt_old that survive an LWR: the high o bytes.
  function automatic logic [31:0] lwr_keep_mask(input logic [1:0] off);
    logic [31:0] m;
    case (off)
      2'd0:    m = 32'h0000_0000;
      2'd1:    m = 32'hFF00_0000;
      2'd2:    m = 32'hFFFF_0000;
      default: m = 32'hFFFF_FF00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_format.sv
// Combinational load data formatter: lane extraction, sign/zero extension and
// LWL/LWR merge with the old register value. Little-endian byte order.
module load_format
  import mips_pkg::*;
(
  input  load_op_t    op,
  input  logic [1:0]  offset,
  input  logic [31:0] readdata,
  input  logic [31:0] rt_old,
  output logic [31:0] write_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  lwl_sh;
  logic [4:0]  lwr_sh;

  always_comb begin
    byte_sel = readdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? readdata[31:16] : readdata[15:0];
    // 8*(3-o) equals {~o, 3'b000} for a 2-bit offset.
    lwl_sh   = {~offset, 3'b000};
    lwr_sh   = {offset, 3'b000};
  end

  always_comb begin
    write_data = readdata;
    case (op)
      LB:      write_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     write_data = {24'h0, byte_sel};
      LH:      write_data = {{16{half_sel[15]}}, half_sel};
      LHU:     write_data = {16'h0, half_sel};
      LWL:     write_data = (readdata << lwl_sh) | (rt_old & lwl_keep_mask(offset));
      LWR:     write_data = (readdata >> lwr_sh) | (rt_old & lwr_keep_mask(offset));
      default: write_data = readdata;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Single-outstanding load unit: accepts a load, issues one word read on the
// memory bus, then formats the data and writes it to the register file.
module load_writeback
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [4:0]        req_rt,
  input  logic [31:0]       req_rt_old,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic [3:0]        byteenable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic              write_en,
  output logic [4:0]        write_addr,
  output logic [31:0]       write_data,
  output logic              addr_err
);

  lw_state_t         state_q, state_d;
  load_op_t          op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        rt_q;
  logic [31:0]       rt_old_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  load_op_t    op_in;
  logic        misaligned_in;
  logic        accept;
  logic [31:0] fmt_data;

  assign op_in         = decode_op(req_op);
  assign misaligned_in = is_misaligned(op_in, req_addr[1:0]);
  assign accept        = req_valid & req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid && !misaligned_in) state_d = READ;
      READ:    if (!waitrequest) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    read       = (state_q == READ);
    byteenable = read ? lane_mask(op_q, addr_q[1:0]) : BE_NONE;
    // r0 is hardwired to zero, so the write is suppressed but the FSM still visits WRITE.
    write_en   = (state_q == WRITE) && (rt_q != 5'd0);
    address    = {addr_q[ADDR_W-1:2], 2'b00};
    write_addr = rt_q;
    write_data = fmt_data;
    addr_err   = err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= LB;
      addr_q   <= '0;
      rt_q     <= '0;
      rt_old_q <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept & misaligned_in;
      if (accept) begin
        op_q     <= op_in;
        addr_q   <= req_addr;
        rt_q     <= req_rt;
        rt_old_q <= req_rt_old;
      end
      if (state_q == READ && !waitrequest) data_q <= readdata;
    end
  end

  load_format u_load_format (
    .op         (op_q),
    .offset     (addr_q[1:0]),
    .readdata   (data_q),
    .rt_old     (rt_old_q),
    .write_data (fmt_data)
  );

endmodule
